// File: rtl/seq_pattern_generator.sv
// Bit-serial pattern transmitter: emits PATTERN (MSB first) Repeat times,
// separated by Gap idle bits, with a Start/Busy/Done handshake.
module seq_pattern_generator #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1101,
  parameter int                   REP_W     = 8,
  parameter int                   GAP_W     = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [REP_W-1:0] Repeat,
  input  logic [GAP_W-1:0] Gap,
  output logic             Dout,
  output logic             Valid,
  output logic             Busy,
  output logic             Done
);

  localparam int IDX_W = (PATTERN_W > 2) ? $clog2(PATTERN_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PATTERN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [REP_W-1:0] frames_left_q, frames_left_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state and counter logic; outputs are decoded from the next state so
  // that they come straight out of flops in the cycle that state is live.
  always_comb begin
    state_d       = state_q;
    bit_idx_d     = bit_idx_q;
    frames_left_d = frames_left_q;
    gap_len_d     = gap_len_q;
    gap_cnt_d     = gap_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          gap_len_d     = Gap;
          frames_left_d = Repeat;
          bit_idx_d     = LAST_IDX;
          if (Repeat == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (bit_idx_q == '0) begin
          frames_left_d = frames_left_q - REP_W'(1);
          if (frames_left_q == REP_W'(1)) begin
            state_d = S_DONE;
          end else if (gap_len_q == '0) begin
            bit_idx_d = LAST_IDX;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = gap_len_q;
          end
        end else begin
          bit_idx_d = bit_idx_q - IDX_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          state_d   = S_SEND;
          bit_idx_d = LAST_IDX;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    dout_d  = (state_d == S_SEND) ? PATTERN[bit_idx_d] : 1'b0;
    valid_d = (state_d == S_SEND);
    busy_d  = (state_d == S_SEND) || (state_d == S_GAP);
    done_d  = (state_d == S_DONE);
  end

  // State, counters and registered outputs; reset abandons any burst silently.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      bit_idx_q     <= '0;
      frames_left_q <= '0;
      gap_len_q     <= '0;
      gap_cnt_q     <= '0;
      dout_q        <= 1'b0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_idx_q     <= bit_idx_d;
      frames_left_q <= frames_left_d;
      gap_len_q     <= gap_len_d;
      gap_cnt_q     <= gap_cnt_d;
      dout_q        <= dout_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign Dout  = dout_q;
  assign Valid = valid_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_seq_pattern_generator.sv
// Scoreboard bench for seq_pattern_generator: a burst-level reference model
// queues the expected per-cycle outputs, a monitor pops and compares them.
module tb_seq_pattern_generator;

  localparam logic [3:0] PAT = 4'b1101;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [7:0] Repeat = '0;
  logic [3:0] Gap = '0;
  logic       Dout, Valid, Busy, Done;

  int checks = 0;
  int errors = 0;

  // Expected {Dout,Valid,Busy,Done} per cycle, and expected detector hits per burst.
  logic [3:0] expQ[$];
  int         repQ[$];
  bit         lastDone = 1'b0;

  logic [3:0] expVal, actVal, detWin;
  int         detHits, expHits;

  seq_pattern_generator #(
    .PATTERN_W(4), .PATTERN(4'b1101), .REP_W(8), .GAP_W(4)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Repeat(Repeat), .Gap(Gap),
    .Dout(Dout), .Valid(Valid), .Busy(Busy), .Done(Done)
  );

  // Free-running clock, 10 time units per period.
  always #5 Clock = ~Clock;

  // Builds the full expected output stream of one burst from its rules.
  function automatic void buildBurst(input int r, input int g);
    if (r > 0) begin
      for (int f = 0; f < r; f++) begin
        for (int i = 0; i < 4; i++) expQ.push_back({PAT[3-i], 1'b1, 1'b1, 1'b0});
        if (f < r - 1) begin
          for (int k = 0; k < g; k++) expQ.push_back(4'b0010);
        end
      end
    end
    expQ.push_back(4'b0001);
    repQ.push_back(r);
  endfunction

  // Reference model: a Start seen while the generator is idle launches a burst.
  always @(posedge Clock) begin
    if (Reset) begin
      expQ.delete();
      repQ.delete();
    end else if (Start && expQ.size() == 0 && !lastDone) begin
      buildBurst(int'(Repeat), int'(Gap));
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: compares DUT outputs every cycle and counts 1101 windows on Dout.
  initial begin
    detWin  = '0;
    detHits = 0;
    @(posedge Clock);
    forever begin
      @(negedge Clock);
      if (Reset) begin
        detWin  = '0;
        detHits = 0;
      end
      expVal   = (expQ.size() > 0) ? expQ.pop_front() : 4'b0000;
      lastDone = expVal[0];
      actVal   = {Dout, Valid, Busy, Done};
      checkOutput("outputs{Dout,Valid,Busy,Done}", 32'(actVal), 32'(expVal));
      detWin = {detWin[2:0], Dout};
      if (detWin == 4'b1101) detHits++;
      if (expVal[0]) begin
        if (repQ.size() > 0) begin
          expHits = repQ.pop_front();
          checkOutput("detector_hits", 32'(detHits), 32'(expHits));
        end
        detHits = 0;
      end
    end
  end

  task automatic applyStimulus(input int r, input int g, input int hold);
    @(negedge Clock);
    #1;
    Start  = 1'b1;
    Repeat = 8'(r);
    Gap    = 4'(g);
    repeat (hold) @(negedge Clock);
    #1;
    Start  = 1'b0;
    Repeat = 8'($urandom);
    Gap    = 4'($urandom);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    do begin
      @(negedge Clock);
      #1;
      n++;
    end while ((expQ.size() > 0 || lastDone) && n < budget);
    if (expQ.size() > 0 || lastDone) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout @%0t: %0d entries left after %0d cycles", $time, expQ.size(), n);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge Clock);
    #1;
  endtask

  task automatic pulseReset();
    @(negedge Clock);
    #1;
    Reset = 1'b1;
    @(negedge Clock);
    #1;
    Reset = 1'b0;
  endtask

  // Directed scenarios followed by randomized bursts.
  initial begin
    int r, g, h;
    Start = 1'b1;
    repeat (2) @(negedge Clock);
    #1;
    Reset = 1'b0;
    Start = 1'b0;
    idleCycles(3);

    $display("[TB] single frame");
    applyStimulus(1, 0, 1);
    waitIdle(100);
    idleCycles(2);

    $display("[TB] three frames with gap 2");
    applyStimulus(3, 2, 1);
    waitIdle(100);

    $display("[TB] two frames back to back");
    applyStimulus(2, 0, 1);
    waitIdle(100);

    $display("[TB] zero repeat");
    applyStimulus(0, 3, 1);
    waitIdle(100);

    $display("[TB] start re-asserted mid-burst");
    applyStimulus(4, 1, 1);
    idleCycles(5);
    applyStimulus(7, 5, 2);
    waitIdle(200);

    $display("[TB] reset during second frame");
    applyStimulus(4, 1, 1);
    idleCycles(5);
    pulseReset();
    idleCycles(2);
    applyStimulus(2, 1, 1);
    waitIdle(100);

    $display("[TB] random bursts");
    for (int t = 0; t < 40; t++) begin
      r = int'($urandom_range(0, 5));
      g = int'($urandom_range(0, 3));
      h = int'($urandom_range(1, 3));
      applyStimulus(r, g, h);
      if ($urandom_range(0, 3) == 0) begin
        idleCycles(int'($urandom_range(0, 6)));
        applyStimulus(int'($urandom_range(1, 5)), int'($urandom_range(0, 3)), 1);
      end
      if ($urandom_range(0, 7) == 0) begin
        idleCycles(int'($urandom_range(0, 8)));
        pulseReset();
      end
      waitIdle(300);
      idleCycles(int'($urandom_range(0, 3)));
    end

    idleCycles(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
